fb_mem_arbiter: RTL and testbench

//  Shares one framebuffer memory port between display scanout and a host writer.

---
 rtl/fb_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_fb_mem_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_mem_arbiter.sv
// Framebuffer memory port arbiter: display scanout bursts interleaved
// with single host writes, scanout filling a line buffer.
module fb_mem_arbiter #(
    parameter int H_ACT  = 640,
    parameter int V_ACT  = 480,
    parameter int BURST  = 16,
    parameter int ADDR_W = 22,
    parameter int DATA_W = 16
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iLine_Start,
    input  logic [9:0]        iLine_Y,
    output logic              oPix_Valid,
    output logic [9:0]        oPix_Index,
    output logic [DATA_W-1:0] oPix_Data,
    output logic              oLine_Done,
    output logic              oUnderrun,
    input  logic              iHost_Req,
    input  logic [ADDR_W-1:0] iHost_Addr,
    input  logic [DATA_W-1:0] iHost_Data,
    output logic              oHost_Ack,
    output logic [ADDR_W-1:0] oMem_Addr,
    output logic              oMem_Read,
    output logic              oMem_Write,
    output logic [DATA_W-1:0] oMem_WData,
    input  logic              iMem_Wait,
    input  logic              iMem_RValid,
    input  logic [DATA_W-1:0] iMem_RData
);
    localparam int CW = $clog2(H_ACT + 1);
    localparam int BW = $clog2(BURST + 1);

    typedef enum logic [1:0] {IDLE, RD_CMD, RD_WAIT, WR} state_t;

    state_t            state;
    logic              active;
    logic              alt;
    logic [ADDR_W-1:0] base;
    logic [CW-1:0]     cc;
    logic [CW-1:0]     rc;
    logic [CW-1:0]     pend;
    logic [CW-1:0]     drop;
    logic [BW-1:0]     bc;

    logic          startOk;
    logic          rdAcc;
    logic          retIn;
    logic          fwd;
    logic          lastWord;
    logic          rdOk;
    logic [CW-1:0] rcNext;
    logic [CW-1:0] pendNext;

    assign startOk  = iLine_Start && (32'(iLine_Y) < V_ACT);
    assign rdAcc    = oMem_Read && !iMem_Wait;
    assign retIn    = iMem_RValid && (pend != '0);
    // returns owed to an aborted line are swallowed before forwarding resumes
    assign fwd      = retIn && (drop == '0) && active;
    assign lastWord = fwd && (rc == CW'(H_ACT - 1));
    assign rdOk     = active && (cc < CW'(H_ACT));
    assign rcNext   = fwd ? rc + 1'b1 : rc;

    assign oHost_Ack  = oMem_Write && !iMem_Wait;
    assign oPix_Valid = fwd;
    assign oPix_Index = fwd ? 10'(rc) : '0;
    assign oPix_Data  = fwd ? iMem_RData : '0;

    always_comb begin
        pendNext = pend;
        if (rdAcc) pendNext = pendNext + 1'b1;
        if (retIn) pendNext = pendNext - 1'b1;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state      <= IDLE;
            active     <= 1'b0;
            alt        <= 1'b0;
            base       <= '0;
            cc         <= '0;
            rc         <= '0;
            pend       <= '0;
            drop       <= '0;
            bc         <= '0;
            oMem_Addr  <= '0;
            oMem_Read  <= 1'b0;
            oMem_Write <= 1'b0;
            oMem_WData <= '0;
            oLine_Done <= 1'b0;
            oUnderrun  <= 1'b0;
        end else begin
            oLine_Done <= lastWord;
            oUnderrun  <= 1'b0;
            pend       <= pendNext;
            rc         <= rcNext;
            if (retIn && drop != '0) drop <= drop - 1'b1;
            if (lastWord) active <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (rdOk && !(iHost_Req && alt)) begin
                        state     <= RD_CMD;
                        oMem_Read <= 1'b1;
                        oMem_Addr <= base + ADDR_W'(cc);
                        bc        <= '0;
                    end else if (iHost_Req) begin
                        state      <= WR;
                        oMem_Write <= 1'b1;
                        oMem_Addr  <= iHost_Addr;
                        oMem_WData <= iHost_Data;
                        alt        <= 1'b0;
                    end
                end
                RD_CMD: begin
                    if (!iMem_Wait) begin
                        cc        <= cc + 1'b1;
                        bc        <= bc + 1'b1;
                        oMem_Addr <= base + ADDR_W'(cc + 1'b1);
                        if (bc == BW'(BURST - 1)) begin
                            state     <= RD_WAIT;
                            oMem_Read <= 1'b0;
                            alt       <= 1'b1;
                        end
                    end
                end
                RD_WAIT: begin
                    if (rcNext == cc) state <= IDLE;
                end
                WR: begin
                    if (!iMem_Wait) begin
                        state      <= IDLE;
                        oMem_Write <= 1'b0;
                    end
                end
            endcase

            // a new line overrides everything except a write already on the bus
            if (startOk) begin
                base      <= ADDR_W'(iLine_Y) * ADDR_W'(H_ACT);
                active    <= 1'b1;
                cc        <= '0;
                rc        <= '0;
                drop      <= pendNext;
                oUnderrun <= active && !lastWord;
                if (state != WR) begin
                    state      <= IDLE;
                    oMem_Read  <= 1'b0;
                    oMem_Write <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Randomised bench for fb_mem_arbiter: memory model with in-order
// returns, host writer, and a per-line reference built from addresses.
module tb_fb_mem_arbiter;
    localparam int H_ACT = 640;
    localparam int V_ACT = 480;
    localparam int BURST = 16;
    localparam int AW    = 22;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          iLine_Start = 1'b0;
    logic [9:0]    iLine_Y = '0;
    logic          oPix_Valid;
    logic [9:0]    oPix_Index;
    logic [DW-1:0] oPix_Data;
    logic          oLine_Done;
    logic          oUnderrun;
    logic          iHost_Req = 1'b0;
    logic [AW-1:0] iHost_Addr = '0;
    logic [DW-1:0] iHost_Data = '0;
    logic          oHost_Ack;
    logic [AW-1:0] oMem_Addr;
    logic          oMem_Read;
    logic          oMem_Write;
    logic [DW-1:0] oMem_WData;
    logic          iMem_Wait = 1'b0;
    logic          iMem_RValid = 1'b0;
    logic [DW-1:0] iMem_RData = '0;

    always #5 clk = ~clk;

    fb_mem_arbiter #(
        .H_ACT(H_ACT), .V_ACT(V_ACT), .BURST(BURST),
        .ADDR_W(AW), .DATA_W(DW)
    ) dut (
        .iCLK(clk), .iRST(rst),
        .iLine_Start(iLine_Start), .iLine_Y(iLine_Y),
        .oPix_Valid(oPix_Valid), .oPix_Index(oPix_Index),
        .oPix_Data(oPix_Data), .oLine_Done(oLine_Done),
        .oUnderrun(oUnderrun),
        .iHost_Req(iHost_Req), .iHost_Addr(iHost_Addr),
        .iHost_Data(iHost_Data), .oHost_Ack(oHost_Ack),
        .oMem_Addr(oMem_Addr), .oMem_Read(oMem_Read),
        .oMem_Write(oMem_Write), .oMem_WData(oMem_WData),
        .iMem_Wait(iMem_Wait), .iMem_RValid(iMem_RValid),
        .iMem_RData(iMem_RData)
    );

    int nPass = 0;
    int nTotal = 0;
    int cyc = 0;
    int lat = 2;
    bit waitMode = 1'b0;
    bit hostOn = 1'b0;

    typedef struct {int addr; int due;} rd_t;
    logic [DW-1:0] mem[int];
    rd_t   rq[$];
    int    lastDue = 0;
    int    rdAddr[$];
    bit    evSeq[$];
    int    pixIdx[$];
    int    pixDat[$];
    int    nDone = 0, nUnder = 0, nAck = 0, nWr = 0;
    int    nOverlap = 0, hostBad = 0;
    bit    wrAcc;

    function automatic logic [DW-1:0] memf(input int a);
        if (mem.exists(a)) return mem[a];
        return DW'(a ^ (a >> 5) ^ 32'h5A3C);
    endfunction

    // memory and host model
    always @(posedge clk) begin
        cyc++;
        if (oMem_Read && !iMem_Wait) begin
            int d;
            d = cyc + lat - 1;
            if (d <= lastDue) d = lastDue + 1;
            lastDue = d;
            rq.push_back(rd_t'{int'(oMem_Addr), d});
            rdAddr.push_back(int'(oMem_Addr));
            evSeq.push_back(1'b1);
        end
        wrAcc = oMem_Write && !iMem_Wait;
        if (wrAcc) begin
            if (oMem_Addr !== iHost_Addr || oMem_WData !== iHost_Data) hostBad++;
            mem[int'(oMem_Addr)] = oMem_WData;
            nWr++;
            evSeq.push_back(1'b0);
        end
        #1;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            iMem_RValid = 1'b1;
            iMem_RData  = memf(rq[0].addr);
            void'(rq.pop_front());
        end else begin
            iMem_RValid = 1'b0;
            iMem_RData  = '0;
        end
        iMem_Wait = waitMode ? cyc[0] : 1'b0;
        if (wrAcc || (!iHost_Req && hostOn)) begin
            iHost_Req  = hostOn;
            iHost_Addr = AW'(32'h200000 + $urandom_range(0, 32'hFFFF));
            iHost_Data = DW'($urandom);
        end
    end

    always @(negedge clk) begin
        if (oPix_Valid) begin
            pixIdx.push_back(int'(oPix_Index));
            pixDat.push_back(int'(oPix_Data));
        end
        if (oLine_Done) nDone++;
        if (oUnderrun) nUnder++;
        if (oHost_Ack) nAck++;
        if (oMem_Read && oMem_Write) nOverlap++;
    end

    task automatic clear_logs();
        rdAddr.delete();
        evSeq.delete();
        pixIdx.delete();
        pixDat.delete();
    endtask

    task automatic pulse_start(input int y);
        @(posedge clk); #2;
        iLine_Y = 10'(y);
        iLine_Start = 1'b1;
        @(posedge clk); #2;
        iLine_Start = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (nDone > d0) begin ok = 1'b1; break; end
        end
        repeat (8) @(negedge clk);
    endtask

    function automatic int pix_bad(input int y);
        int b = 0;
        for (int i = 0; i < pixIdx.size(); i++)
            if (pixIdx[i] != i || pixDat[i] != int'(memf(y * H_ACT + i))) b++;
        return b;
    endfunction

    function automatic int rd_bad(input int y);
        int b = 0;
        for (int i = 0; i < rdAddr.size(); i++)
            if (rdAddr[i] != y * H_ACT + i) b++;
        return b;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        nTotal++;
        if ({oMem_Read, oMem_Write, oPix_Valid, oLine_Done, oUnderrun, oHost_Ack} !== 6'b0)
            $display("FAIL reset_strobes: got %b want 000000",
                     {oMem_Read, oMem_Write, oPix_Valid, oLine_Done, oUnderrun, oHost_Ack});
        else nPass++;
        nTotal++;
        if (oMem_Addr !== '0 || oMem_WData !== '0 || oPix_Index !== '0 || oPix_Data !== '0)
            $display("FAIL reset_data: addr %0h wdata %0h idx %0d pix %0h want 0",
                     oMem_Addr, oMem_WData, oPix_Index, oPix_Data);
        else nPass++;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    task automatic test_line0();
        bit ok;
        int d0;
        lat = 2; waitMode = 1'b0;
        clear_logs();
        d0 = nDone;
        pulse_start(0);
        wait_done(d0, ok);
        nTotal++;
        if (!ok) $display("FAIL line0_timeout: got no done want done"); else nPass++;
        nTotal++;
        if (nDone - d0 != 1) $display("FAIL line0_done_cnt: got %0d want 1", nDone - d0); else nPass++;
        nTotal++;
        if (rdAddr.size() != H_ACT || rd_bad(0) != 0)
            $display("FAIL line0_reads: got %0d reads %0d bad want %0d 0", rdAddr.size(), rd_bad(0), H_ACT);
        else nPass++;
        nTotal++;
        if (pixIdx.size() != H_ACT || pix_bad(0) != 0)
            $display("FAIL line0_pix: got %0d pix %0d bad want %0d 0", pixIdx.size(), pix_bad(0), H_ACT);
        else nPass++;
    endtask

    task automatic test_last_line();
        bit ok;
        int d0;
        clear_logs();
        d0 = nDone;
        pulse_start(V_ACT - 1);
        wait_done(d0, ok);
        nTotal++;
        if (!ok || rdAddr.size() != H_ACT)
            $display("FAIL last_reads: got ok=%0d n=%0d want 1 %0d", ok, rdAddr.size(), H_ACT);
        else nPass++;
        nTotal++;
        if (rdAddr.size() == 0 || rdAddr[0] != 306560 || rdAddr[$] != 307199)
            $display("FAIL last_addr: got first %0d last %0d want 306560 307199",
                     rdAddr.size() ? rdAddr[0] : -1, rdAddr.size() ? rdAddr[$] : -1);
        else nPass++;
        nTotal++;
        if (pixIdx.size() != H_ACT || pix_bad(V_ACT - 1) != 0)
            $display("FAIL last_pix: got %0d pix %0d bad want %0d 0",
                     pixIdx.size(), pix_bad(V_ACT - 1), H_ACT);
        else nPass++;
    endtask

    task automatic test_host();
        bit ok;
        int d0, a0, w0, first, last, run, badRun, wb;
        lat = 2; waitMode = 1'b0;
        hostOn = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        clear_logs();
        d0 = nDone; a0 = nAck; w0 = nWr;
        pulse_start(1);
        wait_done(d0, ok);
        hostOn = 1'b0;
        for (int i = 0; i < 50 && iHost_Req; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        first = -1; last = -1;
        for (int i = 0; i < evSeq.size(); i++)
            if (evSeq[i]) begin
                if (first < 0) first = i;
                last = i;
            end
        run = 0; badRun = 0; wb = 0;
        if (first >= 0) begin
            for (int i = first; i <= last; i++)
                if (evSeq[i]) run++;
                else begin
                    if (run != BURST) badRun++;
                    wb++;
                    run = 0;
                end
        end
        if (run != BURST) badRun++;
        nTotal++;
        if (!ok || iHost_Req) $display("FAIL host_timeout: got ok=%0d req=%0d want 1 0", ok, iHost_Req);
        else nPass++;
        nTotal++;
        if (wb != H_ACT / BURST - 1 || badRun != 0)
            $display("FAIL host_interleave: got %0d writes %0d bad bursts want %0d 0",
                     wb, badRun, H_ACT / BURST - 1);
        else nPass++;
        nTotal++;
        if (nAck - a0 != nWr - w0 || nWr - w0 < wb)
            $display("FAIL host_ack_cnt: got %0d acks want %0d", nAck - a0, nWr - w0);
        else nPass++;
        nTotal++;
        if (hostBad != 0) $display("FAIL host_payload: got %0d bad want 0", hostBad); else nPass++;
        nTotal++;
        if (pixIdx.size() != H_ACT || pix_bad(1) != 0)
            $display("FAIL host_pix: got %0d pix %0d bad want %0d 0", pixIdx.size(), pix_bad(1), H_ACT);
        else nPass++;
    endtask

    task automatic test_wait_toggle();
        bit ok;
        int d0, y;
        lat = $urandom_range(1, 4);
        y = $urandom_range(2, V_ACT - 2);
        waitMode = 1'b1;
        clear_logs();
        d0 = nDone;
        pulse_start(y);
        wait_done(d0, ok);
        waitMode = 1'b0;
        nTotal++;
        if (!ok || rdAddr.size() != H_ACT || rd_bad(y) != 0)
            $display("FAIL wait_reads: got ok=%0d n=%0d bad=%0d want 1 %0d 0", ok, rdAddr.size(), rd_bad(y), H_ACT);
        else nPass++;
        nTotal++;
        if (pixIdx.size() != H_ACT || pix_bad(y) != 0)
            $display("FAIL wait_pix: got %0d pix %0d bad want %0d 0", pixIdx.size(), pix_bad(y), H_ACT);
        else nPass++;
    endtask

    task automatic test_underrun();
        bit ok;
        int d0, u0, ya, yb;
        lat = 3;
        ya = $urandom_range(0, V_ACT - 1);
        yb = (ya + 1 + $urandom_range(0, 100)) % V_ACT;
        clear_logs();
        pulse_start(ya);
        for (int i = 0; i < 2000 && pixIdx.size() < 100; i++) @(negedge clk);
        @(posedge clk); #2;
        iLine_Y = 10'(yb);
        iLine_Start = 1'b1;
        @(posedge clk); #2;
        iLine_Start = 1'b0;
        clear_logs();
        d0 = nDone; u0 = nUnder;
        wait_done(d0, ok);
        nTotal++;
        if (nUnder - u0 != 1) $display("FAIL underrun_pulse: got %0d want 1", nUnder - u0); else nPass++;
        nTotal++;
        if (!ok || nDone - d0 != 1) $display("FAIL underrun_done: got %0d want 1", nDone - d0); else nPass++;
        nTotal++;
        if (rdAddr.size() != H_ACT || rd_bad(yb) != 0)
            $display("FAIL underrun_reads: got %0d reads %0d bad want %0d 0", rdAddr.size(), rd_bad(yb), H_ACT);
        else nPass++;
        nTotal++;
        if (pixIdx.size() != H_ACT || pix_bad(yb) != 0)
            $display("FAIL underrun_pix: got %0d pix %0d bad want %0d 0", pixIdx.size(), pix_bad(yb), H_ACT);
        else nPass++;
    endtask

    task automatic test_ignored_start();
        bit ok;
        int d0, u0, y;
        lat = 2;
        clear_logs();
        u0 = nUnder;
        pulse_start(V_ACT + 20);
        repeat (40) @(negedge clk);
        nTotal++;
        if (rdAddr.size() != 0 || nUnder != u0)
            $display("FAIL ignore_idle: got %0d reads %0d underruns want 0 0", rdAddr.size(), nUnder - u0);
        else nPass++;
        y = $urandom_range(0, V_ACT - 1);
        d0 = nDone;
        pulse_start(y);
        for (int i = 0; i < 2000 && pixIdx.size() < 50; i++) @(negedge clk);
        pulse_start(V_ACT + 120);
        wait_done(d0, ok);
        nTotal++;
        if (!ok || nUnder != u0) $display("FAIL ignore_active: got ok=%0d und=%0d want 1 0", ok, nUnder - u0);
        else nPass++;
        nTotal++;
        if (pixIdx.size() != H_ACT || pix_bad(y) != 0)
            $display("FAIL ignore_pix: got %0d pix %0d bad want %0d 0", pixIdx.size(), pix_bad(y), H_ACT);
        else nPass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int d0, y, n0;
        lat = 4;
        y = $urandom_range(0, V_ACT - 1);
        clear_logs();
        pulse_start(y);
        for (int i = 0; i < 2000 && !(rdAddr.size() >= 40 && oMem_Read); i++) @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        nTotal++;
        if ({oMem_Read, oMem_Write, oPix_Valid, oLine_Done, oUnderrun} !== 5'b0 || oMem_Addr !== '0)
            $display("FAIL midreset_out: got %b addr %0h want 00000 0",
                     {oMem_Read, oMem_Write, oPix_Valid, oLine_Done, oUnderrun}, oMem_Addr);
        else nPass++;
        n0 = pixIdx.size();
        repeat (12) @(negedge clk);
        nTotal++;
        if (pixIdx.size() != n0) $display("FAIL midreset_late: got %0d pix want 0", pixIdx.size() - n0);
        else nPass++;
        y = $urandom_range(0, V_ACT - 1);
        lat = 2;
        clear_logs();
        d0 = nDone;
        pulse_start(y);
        wait_done(d0, ok);
        nTotal++;
        if (!ok || rdAddr.size() != H_ACT || rd_bad(y) != 0 || pixIdx.size() != H_ACT || pix_bad(y) != 0)
            $display("FAIL midreset_line: got ok=%0d rd=%0d pix=%0d bad=%0d want 1 %0d %0d 0",
                     ok, rdAddr.size(), pixIdx.size(), pix_bad(y), H_ACT, H_ACT);
        else nPass++;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        test_reset();
        repeat (2) @(posedge clk);
        test_line0();
        test_last_line();
        test_host();
        test_wait_toggle();
        test_underrun();
        test_ignored_start();
        test_reset_mid();
        nTotal++;
        if (nOverlap != 0) $display("FAIL strobe_overlap: got %0d want 0", nOverlap); else nPass++;
        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end
endmodule
